// File: rtl/voice_mixer.sv
// -----------------------------------------------------------------------------
// voice_mixer
//
// Per-sample mixing stage for NUM_VOICES voice channels. Each frame it collects
// one enveloped sample per voice and sums them. The sum is then scaled by the
// master volume with a serial shift-add multiplier (operand {vol_i,vol_i},
// LSB first, one bit per cycle). The result is saturated to OUT_W bits.
//
// Optional feature (macro VOICE_MIXER_CLIP_CNT_EN):
//   When this macro is defined, the module gets an extra output port
//   clip_cnt_o. It is an 8-bit counter of saturated frames and holds at 255.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous reset, active-low
//   sample_tick_i  frame start pulse
//   voice_valid_i  voice sample offered
//   voice_idx_i    voice number (IDX_W bits)
//   voice_data_i   unsigned voice sample (IN_W bits)
//   voice_ready_o  mixer accepts a sample this cycle
//   vol_i          master volume (VOL_W bits)
//   wave_o         mixed output, held between frames
//   wave_valid_o   1-cycle pulse when wave_o updates
//   clip_cnt_o     saturation count (only with VOICE_MIXER_CLIP_CNT_EN)
//   overrun_o      sticky flag, set when an early tick aborts a frame
// -----------------------------------------------------------------------------
module voice_mixer #(
  parameter int NUM_VOICES = 3,
  parameter int IN_W       = 14,
  parameter int OUT_W      = 10,
  parameter int VOL_W      = 4,
  localparam int IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sample_tick_i,
  input  logic             voice_valid_i,
  input  logic [IDX_W-1:0] voice_idx_i,
  input  logic [IN_W-1:0]  voice_data_i,
  output logic             voice_ready_o,
  input  logic [VOL_W-1:0] vol_i,
  output logic [OUT_W-1:0] wave_o,
  output logic             wave_valid_o,
`ifdef VOICE_MIXER_CLIP_CNT_EN
  output logic [7:0]       clip_cnt_o,
`endif
  output logic             overrun_o
);

  localparam int ACC_W  = IN_W + $clog2(NUM_VOICES + 1);
  localparam int MUL_W  = 2 * VOL_W;
  localparam int PROD_W = ACC_W + MUL_W;
  localparam int CNT_W  = (MUL_W > 1) ? $clog2(MUL_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_W - 1);
  localparam logic [ACC_W-1:0] OUT_MAX  = ACC_W'((2 ** OUT_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCALE, S_OUT} state_t;

  state_t                r_state;
  logic [ACC_W-1:0]      r_acc;
  logic [NUM_VOICES-1:0] r_mask;
  logic [CNT_W-1:0]      r_cnt;
  logic [OUT_W-1:0]      r_wave;
  logic                  r_wave_valid;
  logic                  r_overrun;
  logic [PROD_W-1:0]     r_prod;
  logic [PROD_W-1:0]     r_mcand;
  logic [MUL_W-1:0]      r_mplier;
`ifdef VOICE_MIXER_CLIP_CNT_EN
  logic [7:0]            r_clip_cnt;
`endif

  logic [NUM_VOICES-1:0] w_sel;
  logic                  w_new;
  logic [NUM_VOICES-1:0] w_mask_next;
  logic [ACC_W-1:0]      w_acc_next;
  logic [PROD_W-1:0]     w_prod_next;
  logic [ACC_W-1:0]      w_scaled;

  function automatic logic [OUT_W-1:0] sat_out(input logic [ACC_W-1:0] q);
    if (q > OUT_MAX) return {OUT_W{1'b1}};
    else             return q[OUT_W-1:0];
  endfunction

  function automatic logic is_clip(input logic [ACC_W-1:0] q);
    return (q > OUT_MAX);
  endfunction

  // An out-of-range index selects no voice, so it is accepted and dropped.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (voice_idx_i == IDX_W'(i)) w_sel[i] = 1'b1;
    end
    w_new       = (r_state == S_ACCUM) && voice_valid_i && |(w_sel & ~r_mask);
    w_mask_next = w_new ? (r_mask | w_sel) : r_mask;
    w_acc_next  = w_new ? (r_acc + ACC_W'(voice_data_i)) : r_acc;
    w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    w_scaled    = w_prod_next[PROD_W-1:MUL_W];
  end

  // Control: state machine, accumulator and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_mask       <= '0;
      r_cnt        <= '0;
      r_wave       <= '0;
      r_wave_valid <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef VOICE_MIXER_CLIP_CNT_EN
      r_clip_cnt   <= '0;
`endif
    end else begin
      r_wave_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sample_tick_i) begin
            r_acc   <= '0;
            r_mask  <= '0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          // A tick wins over a same-cycle handshake: the whole frame is dropped.
          if (sample_tick_i) begin
            r_overrun <= 1'b1;
            r_acc     <= '0;
            r_mask    <= '0;
          end else begin
            r_acc  <= w_acc_next;
            r_mask <= w_mask_next;
            r_cnt  <= '0;
            if (&w_mask_next) r_state <= S_SCALE;
          end
        end
        S_SCALE: begin
          if (sample_tick_i) begin
            r_overrun <= 1'b1;
            r_acc     <= '0;
            r_mask    <= '0;
            r_state   <= S_ACCUM;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            // The last partial product is folded in here, so OUT shows the result.
            if (r_cnt == CNT_LAST) begin
              r_wave       <= sat_out(w_scaled);
              r_wave_valid <= 1'b1;
              r_state      <= S_OUT;
`ifdef VOICE_MIXER_CLIP_CNT_EN
              if (is_clip(w_scaled) && (r_clip_cnt != 8'hFF))
                r_clip_cnt <= r_clip_cnt + 8'd1;
`endif
            end
          end
        end
        S_OUT: begin
          if (sample_tick_i) begin
            r_acc   <= '0;
            r_mask  <= '0;
            r_state <= S_ACCUM;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath: multiplier operands reload every ACCUM cycle, so the volume is
  // captured on the edge that enters SCALE.
  always_ff @(posedge clk_i) begin
    if (r_state == S_ACCUM) begin
      r_prod   <= '0;
      r_mcand  <= PROD_W'(w_acc_next);
      r_mplier <= {vol_i, vol_i};
    end else if (r_state == S_SCALE) begin
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign voice_ready_o = (r_state == S_ACCUM);
  assign wave_o        = r_wave;
  assign wave_valid_o  = r_wave_valid;
  assign overrun_o     = r_overrun;
`ifdef VOICE_MIXER_CLIP_CNT_EN
  assign clip_cnt_o    = r_clip_cnt;
`else
  // Without the counter the saturation flag is unused; tie it off explicitly.
  logic w_clip_unused;
  assign w_clip_unused = is_clip(w_scaled);
`endif

endmodule

// File: tb/tb_voice_mixer.sv
module tb_voice_mixer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        sample_tick_i;
  logic        voice_valid_i;
  logic [1:0]  voice_idx_i;
  logic [13:0] voice_data_i;
  logic        voice_ready_o;
  logic [3:0]  vol_i;
  logic [9:0]  wave_o;
  logic        wave_valid_o;
  logic        overrun_o;
`ifdef VOICE_MIXER_CLIP_CNT_EN
  logic [7:0]  clip_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  voice_mixer dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sample_tick_i (sample_tick_i),
    .voice_valid_i (voice_valid_i),
    .voice_idx_i   (voice_idx_i),
    .voice_data_i  (voice_data_i),
    .voice_ready_o (voice_ready_o),
    .vol_i         (vol_i),
    .wave_o        (wave_o),
    .wave_valid_o  (wave_valid_o),
`ifdef VOICE_MIXER_CLIP_CNT_EN
    .clip_cnt_o    (clip_cnt_o),
`endif
    .overrun_o     (overrun_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int exp_wave = 0;
  int exp_clip = 0;
  int exp_ovr  = 0;

  // Mixed value from plain arithmetic: sum * (17*vol) / 256, clipped to 1023.
  function automatic int mix(input int sum, input int vol);
    int q;
    q = (sum * (vol * 17)) / 256;
    return (q > 1023) ? 1023 : q;
  endfunction

  function automatic bit clips(input int sum, input int vol);
    return ((sum * (vol * 17)) / 256) > 1023;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic tick();
    sample_tick_i = 1'b1;
    step();
    sample_tick_i = 1'b0;
  endtask

  task automatic send(input int idx, input int data);
    int n;
    n = 0;
    while (!voice_ready_o && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    voice_valid_i = 1'b1;
    voice_idx_i   = 2'(idx);
    voice_data_i  = 14'(data);
    step();
    voice_valid_i = 1'b0;
  endtask

  task automatic model_frame(input int sum, input int vol);
    exp_wave = mix(sum, vol);
    if (clips(sum, vol) && exp_clip < 255) exp_clip++;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!wave_valid_o && n < 40) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_wave"}, 32'(wave_o), 32'(exp_wave));
`ifdef VOICE_MIXER_CLIP_CNT_EN
    check({tag, "_clipcnt"}, 32'(clip_cnt_o), 32'(exp_clip));
`endif
    step();
    check({tag, "_pulse_end"}, 32'(wave_valid_o), 32'd0);
    check({tag, "_overrun"}, 32'(overrun_o), 32'(exp_ovr));
  endtask

  task automatic frame(input string tag, input bit do_tick, input int vol,
                       input int d0, input int d1, input int d2);
    vol_i = 4'(vol);
    if (do_tick) tick();
    send(0, d0);
    send(1, d1);
    send(2, d2);
    model_frame(d0 + d1 + d2, vol);
    wait_out(tag);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (wave_valid_o) seen++;
      step();
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst_ni        = 1'b0;
    sample_tick_i = 1'b0;
    voice_valid_i = 1'b0;
    voice_idx_i   = '0;
    voice_data_i  = '0;
    vol_i         = '0;
    step();
    step();

    // Reset state
    check("rst_wave", 32'(wave_o), 32'd0);
    check("rst_valid", 32'(wave_valid_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_ready", 32'(voice_ready_o), 32'd0);
`ifdef VOICE_MIXER_CLIP_CNT_EN
    check("rst_clipcnt", 32'(clip_cnt_o), 32'd0);
`endif
    rst_ni = 1'b1;
    step();
    check("idle_ready", 32'(voice_ready_o), 32'd0);

    // T1: basic mix, ready drops during SCALE
    vol_i = 4'd15;
    tick();
    check("T1_ready_accum", 32'(voice_ready_o), 32'd1);
    send(0, 100);
    send(1, 200);
    send(2, 300);
    check("T1_ready_scale", 32'(voice_ready_o), 32'd0);
    model_frame(600, 15);
    check("T1_model", 32'(exp_wave), 32'd597);
    wait_out("T1");

    // T2: saturation
    frame("T2", 1'b1, 15, 1000, 1000, 1000);

    // T3: zero volume still pulses
    frame("T3", 1'b1, 0, 1023, 1023, 1023);

    // T4: early tick aborts the frame
    vol_i = 4'd15;
    tick();
    send(0, 5);
    send(1, 7);
    tick();
    exp_ovr = 1;
    check("T4_overrun", 32'(overrun_o), 32'd1);
    check("T4_ready", 32'(voice_ready_o), 32'd1);
    quiet("T4_no_pulse", 6);
    check("T4_wave_held", 32'(wave_o), 32'(exp_wave));
    frame("T4b", 1'b0, 15, 10, 10, 10);
    check("T4b_value", 32'(wave_o), 32'd29);

    // T5: duplicate index discarded; out-of-range index discarded
    vol_i = 4'd15;
    tick();
    send(0, 50);
    send(0, 70);
    send(3, 999);
    send(1, 0);
    send(2, 0);
    model_frame(50, 15);
    wait_out("T5");

    // T6: reset in the middle of SCALE
    vol_i = 4'd15;
    tick();
    send(0, 1);
    send(1, 2);
    send(2, 3);
    step();
    step();
    step();
    #1;
    rst_ni = 1'b0;
    #1;
    exp_wave = 0;
    exp_ovr  = 0;
    exp_clip = 0;
    check("T6_wave", 32'(wave_o), 32'd0);
    check("T6_valid", 32'(wave_valid_o), 32'd0);
    check("T6_overrun", 32'(overrun_o), 32'd0);
    check("T6_ready", 32'(voice_ready_o), 32'd0);
`ifdef VOICE_MIXER_CLIP_CNT_EN
    check("T6_clipcnt", 32'(clip_cnt_o), 32'd0);
`endif
    step();
    rst_ni = 1'b1;
    quiet("T6_no_partial", 12);
    check("T6_idle_ready", 32'(voice_ready_o), 32'd0);
    frame("T6b", 1'b1, 9, 400, 500, 600);

    // Randomized frames with random order, duplicates and out-of-range indices
    for (int f = 0; f < 10; f++) begin
      int vol, sum, guard, idx, d;
      bit [2:0] seen;
      vol   = $urandom_range(0, 15);
      sum   = 0;
      seen  = '0;
      guard = 0;
      vol_i = 4'(vol);
      tick();
      while (seen != 3'b111 && guard < 40) begin
        idx = $urandom_range(0, 3);
        d   = $urandom_range(0, 16383);
        send(idx, d);
        if (idx < 3 && !seen[idx]) begin
          seen[idx] = 1'b1;
          sum += d;
        end
        guard++;
      end
      if (seen != 3'b111) begin
        for (int v = 0; v < 3; v++) begin
          if (!seen[v]) begin
            d = $urandom_range(0, 16383);
            send(v, d);
            seen[v] = 1'b1;
            sum += d;
          end
        end
      end
      model_frame(sum, vol);
      wait_out($sformatf("R%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
